// File: rtl/ex_bcd2bin64.sv
// Sixteen-digit packed BCD to 64-bit binary converter, one digit per cycle (MSD first),
// with optional ten's-complement interpretation and a valid/ready handshake on both sides.
module ex_bcd2bin64 (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [63:0] i_bcd,
  input  logic        i_mode,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [63:0] o_bin,
  output logic        o_err
);

  localparam logic [63:0] TEN16 = 64'h002386F26FC10000;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIX,
    DONE
  } stateT;

  stateT       state;
  logic [63:0] bcdLatched;
  logic        modeLatched;
  logic [63:0] acc;
  logic [3:0]  cnt;
  logic        err;

  logic [3:0]  digit;
  logic [63:0] accTimesTen;
  logic        negResult;

  assign digit       = bcdLatched[{cnt, 2'b00} +: 4];
  assign accTimesTen = (acc << 3) + (acc << 1);
  // A leading digit of 5 or more marks a negative ten's-complement value.
  assign negResult   = modeLatched && (bcdLatched[63:60] >= 4'd5);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      bcdLatched  <= '0;
      modeLatched <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      o_ready     <= 1'b1;
      o_valid     <= 1'b0;
      o_bin       <= '0;
      o_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            bcdLatched  <= i_bcd;
            modeLatched <= i_mode;
            acc         <= '0;
            err         <= 1'b0;
            cnt         <= 4'd15;
            o_ready     <= 1'b0;
            state       <= CONV;
          end
        end
        CONV: begin
          // Out-of-range nibbles still feed the sum; only the sticky flag records them.
          acc <= accTimesTen + {60'd0, digit};
          if (digit > 4'd9) begin
            err <= 1'b1;
          end
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            state <= FIX;
          end
        end
        FIX: begin
          o_bin   <= negResult ? (acc - TEN16) : acc;
          o_err   <= err;
          o_valid <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
